// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: FSM state encoding, default
// widths and the width of one captured downstream request.
`ifndef SRAM_PORT_ARBITER_PKG_SV
`define SRAM_PORT_ARBITER_PKG_SV

// One captured downstream request, packed as {wr, wstrb, addr, wdata}.
`define MEM_REQ_WD(aw, dw) (1 + ((dw) / 8) + (aw) + (dw))

package sram_port_arbiter_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_D_REQ  = 3'd1,
      S_D_WAIT = 3'd2,
      S_I_REQ  = 3'd3,
      S_I_WAIT = 3'd4,
      S_DONE   = 3'd5
   } state_t;

endpackage

`endif

// File: rtl/sram_port_arbiter_req_capture.sv
// Capture register for one requester: holds the request fields and a pending
// flag from the capture cycle until that requester's transaction completes.
module req_capture_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         capture,
   input  logic         set_pend,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         pend
);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q    <= '0;
         pend <= 1'b0;
      end else if (capture) begin
         q    <= d;
         pend <= set_pend;
      end else if (clear) begin
         q    <= '0;
         pend <= 1'b0;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Serialises the core's data and instruction SRAM requests onto one
// addr_ok/data_ok port, data first, stalling the core until both complete.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                inst_sram_en,
   input  logic [ADDR_W-1:0]   inst_sram_addr,
   output logic [DATA_W-1:0]   inst_sram_rdata,
   input  logic                data_sram_en,
   input  logic [DATA_W/8-1:0] data_sram_wen,
   input  logic [ADDR_W-1:0]   data_sram_addr,
   input  logic [DATA_W-1:0]   data_sram_wdata,
   output logic [DATA_W-1:0]   data_sram_rdata,
   output logic                stallreq,
   output logic                mem_req,
   output logic                mem_wr,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_addr_ok,
   input  logic                mem_data_ok,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int SW = DATA_W / 8;
   localparam int RW = `MEM_REQ_WD(ADDR_W, DATA_W);

   state_t        state_q, state_d;
   logic [RW-1:0] d_req, i_req, d_q, i_q, bus;
   logic          pend_d, pend_i, any_en, capture, done_d, done_i, stall_c;

   assign any_en  = inst_sram_en | data_sram_en;
   assign capture = (state_q == S_IDLE) & any_en;
   assign d_req   = {|data_sram_wen, data_sram_wen, data_sram_addr, data_sram_wdata};
   assign i_req   = {1'b0, {SW{1'b0}}, inst_sram_addr, {DATA_W{1'b0}}};

   req_capture_reg #(.W(RW)) u_data_cap (
      .clk      (clk),
      .resetn   (resetn),
      .capture  (capture),
      .set_pend (data_sram_en),
      .clear    (done_d),
      .d        (d_req),
      .q        (d_q),
      .pend     (pend_d)
   );

   req_capture_reg #(.W(RW)) u_inst_cap (
      .clk      (clk),
      .resetn   (resetn),
      .capture  (capture),
      .set_pend (inst_sram_en),
      .clear    (done_i),
      .d        (i_req),
      .q        (i_q),
      .pend     (pend_i)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      stall_c = 1'b0;
      mem_req = 1'b0;
      done_d  = 1'b0;
      done_i  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            stall_c = any_en;
            if (any_en) state_d = data_sram_en ? S_D_REQ : S_I_REQ;
         end
         S_D_REQ: begin
            stall_c = 1'b1;
            mem_req = 1'b1;
            if (mem_addr_ok) begin
               if (mem_data_ok) begin
                  done_d  = 1'b1;
                  state_d = pend_i ? S_I_REQ : S_DONE;
               end else begin
                  state_d = S_D_WAIT;
               end
            end
         end
         S_D_WAIT: begin
            stall_c = 1'b1;
            if (mem_data_ok && pend_d) begin
               done_d  = 1'b1;
               state_d = pend_i ? S_I_REQ : S_DONE;
            end
         end
         S_I_REQ: begin
            stall_c = 1'b1;
            mem_req = 1'b1;
            if (mem_addr_ok) begin
               if (mem_data_ok) begin
                  done_i  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_I_WAIT;
               end
            end
         end
         S_I_WAIT: begin
            stall_c = 1'b1;
            if (mem_data_ok && pend_i) begin
               done_i  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The core may hold en during reset; the stall must still read 0 then.
   assign stallreq = resetn & stall_c;

   assign bus = !mem_req              ? '0  :
                (state_q == S_D_REQ)  ? d_q : i_q;
   assign {mem_wr, mem_wstrb, mem_addr, mem_wdata} = bus;

   // A store completes without touching the load data register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inst_sram_rdata <= '0;
         data_sram_rdata <= '0;
      end else begin
         if (done_d && !d_q[RW-1]) data_sram_rdata <= mem_rdata;
         if (done_i)               inst_sram_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a scripted downstream responder, a
// core-side stimulus thread and a scoreboard monitor for bus and rdata.
module tb_sram_port_arbiter;

   logic        clk, resetn;
   logic        inst_sram_en, data_sram_en;
   logic [31:0] inst_sram_addr, data_sram_addr, data_sram_wdata;
   logic [3:0]  data_sram_wen;
   logic [31:0] inst_sram_rdata, data_sram_rdata;
   logic        stallreq, mem_req, mem_wr, mem_addr_ok, mem_data_ok;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   typedef struct {
      logic        wr;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          req_cycles;
   } bus_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] data;
   } rd_t;

   bus_t        bus_q[$];
   rd_t         rd_q[$];
   logic [31:0] resp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          addr_delay = 0;
   int          data_delay = 0;
   bit          resp_busy  = 0;

   sram_port_arbiter dut (
      .clk             (clk),
      .resetn          (resetn),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_rdata (inst_sram_rdata),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .stallreq        (stallreq),
      .mem_req         (mem_req),
      .mem_wr          (mem_wr),
      .mem_wstrb       (mem_wstrb),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_addr_ok     (mem_addr_ok),
      .mem_data_ok     (mem_data_ok),
      .mem_rdata       (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic exp_bus(input logic wr, input logic [3:0] wstrb, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] resp);
      bus_t b;
      b.wr = wr; b.wstrb = wstrb; b.addr = addr; b.wdata = wdata;
      b.req_cycles = addr_delay + 1;
      bus_q.push_back(b);
      resp_q.push_back(resp);
   endtask

   task automatic exp_rd(input logic [31:0] inst, input logic [31:0] data);
      rd_t r;
      r.inst = inst; r.data = data;
      rd_q.push_back(r);
   endtask

   task automatic start_req(input logic ie, input logic [31:0] ia, input logic de,
                            input logic [3:0] wen, input logic [31:0] da, input logic [31:0] wd);
      inst_sram_en    = ie;
      inst_sram_addr  = ia;
      data_sram_en    = de;
      data_sram_wen   = wen;
      data_sram_addr  = da;
      data_sram_wdata = wd;
   endtask

   // Counts stalled cycles until the DONE cycle; returns at the following IDLE.
   task automatic wait_done(input string name, input int exp_cycles);
      int n = 0;
      bit done = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk); #1;
         if (stallreq) n++;
         else done = 1;
      end
      check({name, "_reached_done"}, done, 1);
      check({name, "_stall_cycles"}, n, exp_cycles);
      @(posedge clk); #1;
   endtask

   task automatic drop_req();
      inst_sram_en = 1'b0;
      data_sram_en = 1'b0;
      @(posedge clk); #1;
   endtask

   // Downstream responder: addr_ok after addr_delay stalled cycles, data_ok
   // data_delay cycles after acceptance (same cycle when zero).
   initial begin
      bit in_req = 0;
      int acnt = 0;
      int dcnt = 0;
      logic [31:0] rd = '0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = 32'h0BAD0BAD;
      forever begin
         @(negedge clk);
         mem_addr_ok = 1'b0;
         mem_data_ok = 1'b0;
         mem_rdata   = 32'h0BAD0BAD;
         if (resp_busy) begin
            if (dcnt == 0) begin
               mem_data_ok = 1'b1;
               mem_rdata   = rd;
               resp_busy   = 0;
            end else dcnt--;
         end else if (mem_req) begin
            if (!in_req) begin
               in_req = 1;
               acnt   = addr_delay;
            end
            if (acnt == 0) begin
               mem_addr_ok = 1'b1;
               in_req      = 0;
               rd = (resp_q.size() != 0) ? resp_q.pop_front() : 32'hDEAD0000;
               if (data_delay == 0) begin
                  mem_data_ok = 1'b1;
                  mem_rdata   = rd;
               end else begin
                  resp_busy = 1;
                  dcnt      = data_delay - 1;
               end
            end else acnt--;
         end
      end
   end

   // Scoreboard monitor: bus requests against bus_q, DONE-cycle rdata against rd_q.
   initial begin
      bit prev_stall = 0;
      bit prev_rst   = 0;
      int req_cnt    = 0;
      forever begin
         @(negedge clk); #1;
         if (resetn) begin
            if (resp_busy && !mem_addr_ok) check("no_req_during_wait", mem_req, 0);
            if (mem_req) begin
               if (bus_q.size() == 0) check("unexpected_req", mem_req, 0);
               else begin
                  check("bus_wr", mem_wr, bus_q[0].wr);
                  check("bus_wstrb", mem_wstrb, bus_q[0].wstrb);
                  check("bus_addr", mem_addr, bus_q[0].addr);
                  check("bus_wdata", mem_wdata, bus_q[0].wdata);
                  req_cnt++;
                  if (mem_addr_ok) begin
                     check("bus_req_cycles", req_cnt, bus_q[0].req_cycles);
                     bus_q.delete(0);
                     req_cnt = 0;
                  end
               end
            end
            if (prev_rst && prev_stall && !stallreq && (inst_sram_en || data_sram_en)) begin
               if (rd_q.size() == 0) check("unexpected_done", rd_q.size(), 1);
               else begin
                  check("done_inst_rdata", inst_sram_rdata, rd_q[0].inst);
                  check("done_data_rdata", data_sram_rdata, rd_q[0].data);
                  rd_q.delete(0);
               end
            end
         end else req_cnt = 0;
         prev_stall = stallreq;
         prev_rst   = resetn;
      end
   end

   initial begin
      bit ok;
      resetn = 1'b0;
      start_req(1, 32'hBFC00000, 0, 4'h0, 32'h0, 32'h0);
      #12;
      check("rst_stallreq", stallreq, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_mem_wstrb", mem_wstrb, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_inst_rdata", inst_sram_rdata, 0);
      check("rst_data_rdata", data_sram_rdata, 0);
      inst_sram_en = 1'b0;
      #10 resetn = 1'b1;
      @(posedge clk); #1;

      // Instruction fetch only, zero-wait downstream.
      exp_bus(0, 4'h0, 32'hBFC00000, 32'h0, 32'h3C1A0001);
      exp_rd(32'h3C1A0001, 32'h0);
      start_req(1, 32'hBFC00000, 0, 4'h0, 32'h0, 32'h0);
      wait_done("a_fetch", 2);
      drop_req();

      // Simultaneous fetch and load: data goes out first.
      exp_bus(0, 4'h0, 32'h80001000, 32'h0, 32'h11111111);
      exp_bus(0, 4'h0, 32'hBFC00004, 32'h0, 32'h22222222);
      exp_rd(32'h22222222, 32'h11111111);
      start_req(1, 32'hBFC00004, 1, 4'h0, 32'h80001000, 32'h0);
      wait_done("b_both", 3);
      drop_req();

      // Store with addr_ok held off 3 cycles; load data must not change.
      addr_delay = 3;
      exp_bus(1, 4'b0011, 32'h80002000, 32'hDEADBEEF, 32'hA5A5A5A5);
      exp_rd(32'h22222222, 32'h11111111);
      start_req(0, 32'h0, 1, 4'b0011, 32'h80002000, 32'hDEADBEEF);
      wait_done("c_store", 5);
      drop_req();
      addr_delay = 0;

      // Load with data_ok 5 cycles after acceptance.
      data_delay = 5;
      exp_bus(0, 4'h0, 32'h80003000, 32'h0, 32'h33333333);
      exp_rd(32'h22222222, 32'h33333333);
      start_req(0, 32'h0, 1, 4'h0, 32'h80003000, 32'h0);
      wait_done("d_slow", 7);
      drop_req();
      data_delay = 0;

      // en held through DONE with the old address, new address in next IDLE.
      exp_bus(0, 4'h0, 32'hBFC00010, 32'h0, 32'h44444444);
      exp_rd(32'h44444444, 32'h33333333);
      start_req(1, 32'hBFC00010, 0, 4'h0, 32'h0, 32'h0);
      wait_done("e_first", 2);
      exp_bus(0, 4'h0, 32'hBFC00014, 32'h0, 32'h55555555);
      exp_rd(32'h55555555, 32'h33333333);
      start_req(1, 32'hBFC00014, 0, 4'h0, 32'h0, 32'h0);
      wait_done("e_second", 2);
      drop_req();

      // Reset pulsed while waiting for data_ok; the late data_ok is ignored.
      data_delay = 8;
      exp_bus(0, 4'h0, 32'h80004000, 32'h0, 32'h66666666);
      start_req(0, 32'h0, 1, 4'h0, 32'h80004000, 32'h0);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk); #1;
         ok = resp_busy;
      end
      check("f_reached_wait", ok, 1);
      @(negedge clk); #2;
      resetn = 1'b0;
      #1;
      check("f_rst_stallreq", stallreq, 0);
      check("f_rst_mem_req", mem_req, 0);
      check("f_rst_mem_addr", mem_addr, 0);
      check("f_rst_inst_rdata", inst_sram_rdata, 0);
      check("f_rst_data_rdata", data_sram_rdata, 0);
      inst_sram_en = 1'b0;
      data_sram_en = 1'b0;
      repeat (2) @(posedge clk);
      #3 resetn = 1'b1;
      ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk); #1;
         ok = mem_data_ok;
      end
      check("f_late_data_ok_seen", ok, 1);
      @(negedge clk); #1;
      check("f_after_stallreq", stallreq, 0);
      check("f_after_mem_req", mem_req, 0);
      check("f_after_inst_rdata", inst_sram_rdata, 0);
      check("f_after_data_rdata", data_sram_rdata, 0);
      @(posedge clk); #1;
      data_delay = 0;

      // A normal fetch right after proves the FSM is back in IDLE.
      exp_bus(0, 4'h0, 32'hBFC00020, 32'h0, 32'h77777777);
      exp_rd(32'h77777777, 32'h0);
      start_req(1, 32'hBFC00020, 0, 4'h0, 32'h0, 32'h0);
      wait_done("g_after_reset", 2);
      drop_req();

      repeat (2) @(posedge clk);
      #1;
      check("bus_q_drained", bus_q.size(), 0);
      check("rd_q_drained", rd_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one downstream SRAM-like request/response port (addr_ok/data_ok handshake) between the core's instruction-fetch and data-access SRAM interfaces.
- Sits between mycpu_core and the bus bridge.
- Serialises simultaneous requests, data first, then instruction.
- Drives the core's stallreq_from_outside until both requests complete, then presents registered read data with synchronous-SRAM timing.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  input  1  single clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- inst_sram_en  input  1  instruction fetch request.
- inst_sram_addr  input  ADDR_W  fetch address.
- inst_sram_rdata  output  DATA_W  fetched instruction, registered.
- data_sram_en  input  1  data access request.
- data_sram_wen  input  DATA_W/8  byte write strobes; 0 means read.
- data_sram_addr  input  ADDR_W  data address.
- data_sram_wdata  input  DATA_W  store data.
- data_sram_rdata  output  DATA_W  load data, registered.
- stallreq  output  1  to core stallreq_from_outside.
- mem_req  output  1  downstream request valid.
- mem_wr  output  1  1 = write.
- mem_wstrb  output  DATA_W/8  write strobes.
- mem_addr  output  ADDR_W  downstream address.
- mem_wdata  output  DATA_W  downstream write data.
- mem_addr_ok  input  1  request accepted this cycle (handshake with mem_req).
- mem_data_ok  input  1  response valid this cycle.
- mem_rdata  input  DATA_W  response read data.

Behaviour:
- States:
  - IDLE.
  - D_REQ (data request on bus, waiting for addr_ok).
  - D_WAIT (waiting for data_ok).
  - I_REQ.
  - I_WAIT.
  - DONE.
- Reset (resetn=0, asynchronous):
  - State IDLE.
  - inst_sram_rdata = data_sram_rdata = 0.
  - mem_req = mem_wr = 0; mem_wstrb/mem_addr/mem_wdata = 0.
  - Pending flags and capture registers = 0.
  - stallreq = 0 while reset is asserted.
  - Reset mid-transaction abandons it; the downstream port shares the same reset.
- IDLE:
  - stallreq = inst_sram_en | data_sram_en (combinational; same-cycle stall).
  - On any en, capture all request fields and set pend_d = data_sram_en, pend_i = inst_sram_en.
  - Next state D_REQ if data_sram_en, else I_REQ.
  - With no en, remain in IDLE; rdata outputs hold their previous values.
- D_REQ:
  - mem_req = 1 and mem_wr = |wstrb; drive the captured data fields.
  - On mem_addr_ok go to D_WAIT and drop mem_req the next cycle.
  - A request must not be withdrawn or altered before addr_ok.
- D_WAIT:
  - On mem_data_ok, clear pend_d; for a read, load data_sram_rdata <= mem_rdata (a write leaves it unchanged).
  - Next state I_REQ if pend_i, else DONE.
  - addr_ok and data_ok in the same cycle as the request: D_REQ goes straight to I_REQ/DONE, data captured.
- I_REQ / I_WAIT:
  - Same handshake as the data states; always a read, mem_wstrb = 0.
  - On data_ok, inst_sram_rdata <= mem_rdata; next state DONE.
- DONE:
  - stallreq = 0 for exactly one cycle; the core consumes the rdata outputs.
  - The core's en/addr in this cycle still belong to the completed request and are ignored.
  - Next state IDLE unconditionally.
- stallreq is 1 in D_REQ, D_WAIT, I_REQ, I_WAIT; 0 in DONE.
- Min latency:
  - Single request with 0-wait downstream: capture cycle + REQ + DONE = 3 cycles.
  - Both requests: 4 cycles.
- Only one outstanding downstream transaction at any time; a data_ok arriving in IDLE/DONE is ignored.
- rdata outputs are updated only by their own response and hold otherwise, including across write-only requests.
- No timeout; a hang persists until reset.

Decomposition:
- Shared package/defines header holds:
  - State encoding (3-bit localparams S_IDLE, S_D_REQ, S_D_WAIT, S_I_REQ, S_I_WAIT, S_DONE).
  - ADDR_W/DATA_W defaults.
  - A `MEM_REQ_WD` bus-width define for {wr, wstrb, addr, wdata}.
- One natural sub-module, req_capture_reg: the capture register for one requester (latch on capture, clear on completion, pending flag). It is instantiated twice.

Test Plan:
- Inst-only fetch addr 0xBFC00000, 0-wait downstream, mem_rdata 0x3C1A0001.
  - Required: stallreq=1 for 2 cycles then 0 in DONE.
  - inst_sram_rdata = 0x3C1A0001 in DONE.
  - mem_wr never 1.
- Simultaneous fetch 0xBFC00004 + load 0x80001000, responses 0x11111111 (data) and 0x22222222 (inst).
  - Required: data transaction appears on the bus first.
  - data_sram_rdata = 0x11111111, inst_sram_rdata = 0x22222222.
  - stallreq low only in the DONE cycle.
- Store wen=4'b0011, addr 0x80002000, wdata 0xDEADBEEF, with addr_ok delayed 3 cycles.
  - Required: mem_req/mem_addr/mem_wstrb stay stable for 4 cycles; mem_wr = 1.
  - data_sram_rdata unchanged from its prior value.
- data_ok delayed 5 cycles after addr_ok.
  - Required: mem_req = 0 during the wait; stallreq stays 1; no second request is issued.
- resetn pulsed low mid-D_WAIT.
  - Required: outputs zero immediately (asynchronous).
  - A late data_ok after reset release leaves IDLE state and rdata registers unchanged.
- In DONE, inst_sram_en stays 1 with the old addr.
  - Required: no new capture in DONE.
  - A new request is captured in the following IDLE cycle.
